inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 9 +
 rtl/inst_fetch.sv | 80 ++++++++
 tb/tb_inst_fetch.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared bus widths and constants for the instruction fetch stage
package inst_fetch_pkg;
    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;
    localparam logic [InstBus-1:0]     ZeroWord = '0;
    localparam logic                   True_v   = 1'b1;
    localparam logic                   False_v  = 1'b0;
    localparam logic [InstAddrBus-1:0] RstPc    = '0;
endpackage

// File: rtl/inst_fetch.sv
// inst_fetch: fetches 32-bit instructions as four little-endian byte reads and
// hands them to IF/ID through a one-word holding buffer.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable, low freezes all state
//   stall_i             IF/ID not accepting the held instruction
//   branch_enable_i/branch_addr_i   redirect request and target
//   mem_req_o/mem_addr_o/mem_grant_i/mem_din_i   byte-read port (data one cycle after grant)
//   pc_o/inst_o/inst_valid_o        instruction presented to IF/ID
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   stall_i,
    input  logic                   branch_enable_i,
    input  logic [InstAddrBus-1:0] branch_addr_i,
    output logic                   mem_req_o,
    output logic [InstAddrBus-1:0] mem_addr_o,
    input  logic                   mem_grant_i,
    input  logic [7:0]             mem_din_i,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o,
    output logic                   inst_valid_o
);
    logic [InstAddrBus-1:0] fetch_pc;
    logic [InstBus-1:0]     word_q;
    logic [2:0]             issue_cnt, recv_cnt;
    logic                   pending_q, issue, last_byte, buf_full, out_free;

    always_comb begin
        // recv_cnt parked at 4 means a complete word waits behind a stalled output
        buf_full   = recv_cnt == 3'd4;
        mem_req_o  = !rst && rdy && !branch_enable_i && issue_cnt < 3'd4 && !buf_full;
        mem_addr_o = fetch_pc + {29'b0, issue_cnt};
        issue      = mem_req_o && mem_grant_i;
        last_byte  = pending_q && recv_cnt == 3'd3;
        out_free   = !inst_valid_o || !stall_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc     <= RstPc;
            word_q       <= ZeroWord;
            issue_cnt    <= '0;
            recv_cnt     <= '0;
            pending_q    <= False_v;
            pc_o         <= RstPc;
            inst_o       <= ZeroWord;
            inst_valid_o <= False_v;
        end else if (rdy) begin
            if (branch_enable_i) begin
                fetch_pc     <= branch_addr_i;
                issue_cnt    <= '0;
                recv_cnt     <= '0;
                pending_q    <= False_v;
                inst_valid_o <= False_v;
            end else begin
                pending_q <= issue;
                if (issue) issue_cnt <= issue_cnt + 3'd1;
                // the fourth byte goes straight to the output, bypassing word_q
                if ((last_byte && out_free) || (buf_full && !stall_i)) begin
                    pc_o         <= fetch_pc;
                    inst_o       <= last_byte ? {mem_din_i, word_q[23:0]} : word_q;
                    inst_valid_o <= True_v;
                    fetch_pc     <= fetch_pc + 32'd4;
                    issue_cnt    <= '0;
                    recv_cnt     <= '0;
                end else begin
                    if (pending_q) begin
                        word_q[{recv_cnt[1:0], 3'b000} +: 8] <= mem_din_i;
                        recv_cnt <= recv_cnt + 3'd1;
                    end
                    if (!stall_i) inst_valid_o <= False_v;
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scenarios plus randomized traffic against a byte-memory model
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst, rdy, stall_i, branch_enable_i, mem_grant_i;
    logic [31:0] branch_addr_i;
    logic        mem_req_o, inst_valid_o;
    logic [31:0] mem_addr_o, pc_o, inst_o;
    logic [7:0]  mem_din_i;
    logic [7:0]  mem [4096];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk(clk), .rst(rst), .rdy(rdy), .stall_i(stall_i),
        .branch_enable_i(branch_enable_i), .branch_addr_i(branch_addr_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_grant_i(mem_grant_i),
        .mem_din_i(mem_din_i), .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o)
    );

    // memory answers a granted read one cycle later and keeps that byte until the next grant
    always @(posedge clk) if (mem_req_o && mem_grant_i) mem_din_i <= mem[mem_addr_o[11:0]];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] t;
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            t = a + 32'(k);
            w[8*k +: 8] = mem[t[11:0]];
        end
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1; rdy = 1; stall_i = 0; branch_enable_i = 0; branch_addr_i = '0; mem_grant_i = 1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({pc_o, inst_o, inst_valid_o, mem_req_o, mem_addr_o} !== 98'b0) begin
            errors++;
            $display("FAIL reset_state pc=%h inst=%h valid=%b req=%b addr=%h want all zero",
                     pc_o, inst_o, inst_valid_o, mem_req_o, mem_addr_o);
        end
    endtask

    task automatic test_basic();
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk); rst = 0; #1;
            if (c < 4) begin
                checks++;
                if (mem_req_o !== 1'b1 || mem_addr_o !== 32'(c)) begin
                    errors++;
                    $display("FAIL basic_issue c=%0d req=%b addr=%h want req=1 addr=%h", c, mem_req_o, mem_addr_o, c);
                end
            end
            if (c == 4) begin
                checks++;
                if (mem_req_o !== 1'b0) begin errors++; $display("FAIL basic_idle c=4 req=%b want 0", mem_req_o); end
            end
            if (c > 0 && c < 5) begin
                checks++;
                if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL basic_early_valid c=%0d valid=%b want 0", c, inst_valid_o); end
            end
            if (c == 5) begin
                checks++;
                if (inst_valid_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'h00a00513) begin
                    errors++;
                    $display("FAIL basic_word0 valid=%b pc=%h inst=%h want 1 00000000 00a00513", inst_valid_o, pc_o, inst_o);
                end
            end
            if (c == 10) begin
                checks++;
                if (inst_valid_o !== 1'b1 || pc_o !== 32'h4 || inst_o !== word_at(32'h4)) begin
                    errors++;
                    $display("FAIL basic_word1 valid=%b pc=%h inst=%h want 1 00000004 %h", inst_valid_o, pc_o, inst_o, word_at(32'h4));
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk); rst = 0; stall_i = (c >= 5 && c <= 12); #1;
            if (c >= 5 && c <= 12) begin
                checks++;
                if (inst_valid_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'h00a00513) begin
                    errors++;
                    $display("FAIL stall_hold c=%0d valid=%b pc=%h inst=%h want 1 00000000 00a00513", c, inst_valid_o, pc_o, inst_o);
                end
            end
            if (c >= 10 && c <= 12) begin
                checks++;
                if (mem_req_o !== 1'b0) begin errors++; $display("FAIL stall_buf_req c=%0d req=%b want 0", c, mem_req_o); end
            end
            if (c == 14) begin
                checks++;
                if (inst_valid_o !== 1'b1 || pc_o !== 32'h4 || inst_o !== word_at(32'h4) || mem_req_o !== 1'b1 || mem_addr_o !== 32'h8) begin
                    errors++;
                    $display("FAIL stall_release valid=%b pc=%h inst=%h req=%b addr=%h want 1 00000004 %h 1 00000008",
                             inst_valid_o, pc_o, inst_o, mem_req_o, mem_addr_o, word_at(32'h4));
                end
            end
        end
        stall_i = 0;
    endtask

    task automatic test_branch();
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk); rst = 0; branch_enable_i = (c == 2); branch_addr_i = 32'h100; #1;
            if (c == 2) begin
                checks++;
                if (mem_req_o !== 1'b0) begin errors++; $display("FAIL branch_req_cycle req=%b want 0", mem_req_o); end
            end
            if (c == 3) begin
                checks++;
                if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin
                    errors++;
                    $display("FAIL branch_target req=%b addr=%h want 1 00000100", mem_req_o, mem_addr_o);
                end
            end
            if (c >= 3 && c <= 7) begin
                checks++;
                if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL branch_early_valid c=%0d valid=%b want 0", c, inst_valid_o); end
            end
            if (c == 8) begin
                checks++;
                if (inst_valid_o !== 1'b1 || pc_o !== 32'h100 || inst_o !== word_at(32'h100)) begin
                    errors++;
                    $display("FAIL branch_word valid=%b pc=%h inst=%h want 1 00000100 %h", inst_valid_o, pc_o, inst_o, word_at(32'h100));
                end
            end
        end
        branch_enable_i = 0;
    endtask

    task automatic test_grant();
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk); rst = 0; mem_grant_i = !(c >= 2 && c <= 4); #1;
            if (c >= 2 && c <= 4) begin
                checks++;
                if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h2) begin
                    errors++;
                    $display("FAIL grant_hold c=%0d req=%b addr=%h want 1 00000002", c, mem_req_o, mem_addr_o);
                end
            end
            if (c == 7) begin
                checks++;
                if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL grant_early_valid valid=%b want 0", inst_valid_o); end
            end
            if (c == 8) begin
                checks++;
                if (inst_valid_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'h00a00513) begin
                    errors++;
                    $display("FAIL grant_word valid=%b pc=%h inst=%h want 1 00000000 00a00513", inst_valid_o, pc_o, inst_o);
                end
            end
        end
        mem_grant_i = 1;
    endtask

    task automatic test_rdy();
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk); rst = 0; rdy = !(c >= 2 && c <= 5); #1;
            if (c >= 2 && c <= 5) begin
                checks++;
                if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h2 || inst_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rdy_freeze c=%0d req=%b addr=%h valid=%b want 0 00000002 0", c, mem_req_o, mem_addr_o, inst_valid_o);
                end
            end
            if (c == 6) begin
                checks++;
                if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h2) begin
                    errors++;
                    $display("FAIL rdy_resume req=%b addr=%h want 1 00000002", mem_req_o, mem_addr_o);
                end
            end
            if (c == 9) begin
                checks++;
                if (inst_valid_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'h00a00513) begin
                    errors++;
                    $display("FAIL rdy_word valid=%b pc=%h inst=%h want 1 00000000 00a00513", inst_valid_o, pc_o, inst_o);
                end
            end
        end
        rdy = 1;
    endtask

    task automatic test_rst_mid();
        do_reset();
        for (int c = 0; c <= 15; c++) begin
            @(negedge clk); rst = (c == 9); branch_enable_i = (c == 0); branch_addr_i = 32'h40; #1;
            if (c == 6) begin
                checks++;
                if (inst_valid_o !== 1'b1 || pc_o !== 32'h40 || inst_o !== word_at(32'h40)) begin
                    errors++;
                    $display("FAIL rstmid_pre valid=%b pc=%h inst=%h want 1 00000040 %h", inst_valid_o, pc_o, inst_o, word_at(32'h40));
                end
            end
            if (c == 9) begin
                checks++;
                if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rstmid_req req=%b want 0", mem_req_o); end
            end
            if (c == 10) begin
                checks++;
                if ({pc_o, inst_o, inst_valid_o} !== 65'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
                    errors++;
                    $display("FAIL rstmid_clear pc=%h inst=%h valid=%b req=%b addr=%h want 0 0 0 1 0",
                             pc_o, inst_o, inst_valid_o, mem_req_o, mem_addr_o);
                end
            end
            if (c == 15) begin
                checks++;
                if (inst_valid_o !== 1'b1 || pc_o !== 32'h0 || inst_o !== 32'h00a00513) begin
                    errors++;
                    $display("FAIL rstmid_word valid=%b pc=%h inst=%h want 1 00000000 00a00513", inst_valid_o, pc_o, inst_o);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, p_pc, p_inst, base;
        logic        p_valid, hold;
        int          accepted;
        exp_pc = 0; p_pc = 0; p_inst = 0; p_valid = 0; hold = 0; accepted = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst             = ($urandom_range(199) == 0);
            rdy             = ($urandom_range(9) != 0);
            stall_i         = ($urandom_range(9) < 3);
            mem_grant_i     = ($urandom_range(9) < 7);
            branch_enable_i = ($urandom_range(49) == 0);
            branch_addr_i   = ($urandom_range(3) == 0) ? 32'hffff_fffd + $urandom_range(2) : {20'h0, 12'($urandom)};
            #1;
            if (!rst) begin
                if (hold) begin
                    checks++;
                    if (pc_o !== p_pc || inst_o !== p_inst || inst_valid_o !== p_valid) begin
                        errors++;
                        $display("FAIL rand_hold c=%0d pc=%h inst=%h valid=%b want %h %h %b", c, pc_o, inst_o, inst_valid_o, p_pc, p_inst, p_valid);
                    end
                end
                if (inst_valid_o) begin
                    checks++;
                    if (pc_o !== exp_pc || inst_o !== word_at(exp_pc)) begin
                        errors++;
                        $display("FAIL rand_word c=%0d pc=%h inst=%h want %h %h", c, pc_o, inst_o, exp_pc, word_at(exp_pc));
                    end
                end
                if (!rdy || branch_enable_i) begin
                    checks++;
                    if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rand_req_off c=%0d req=%b want 0", c, mem_req_o); end
                end
                if (mem_req_o) begin
                    base = inst_valid_o ? exp_pc + 32'd4 : exp_pc;
                    checks++;
                    if (mem_addr_o - base > 32'd3) begin
                        errors++;
                        $display("FAIL rand_addr c=%0d addr=%h want %h..+3", c, mem_addr_o, base);
                    end
                end
                if (rdy && !branch_enable_i && inst_valid_o && !stall_i) begin
                    exp_pc = exp_pc + 32'd4;
                    accepted++;
                end
                if (rdy && branch_enable_i) exp_pc = branch_addr_i;
            end else exp_pc = 0;
            hold    = !rst && (!rdy || (!branch_enable_i && inst_valid_o && stall_i));
            p_pc    = pc_o;
            p_inst  = inst_o;
            p_valid = inst_valid_o;
        end
        checks++;
        if (accepted < 50) begin errors++; $display("FAIL rand_progress accepted=%0d want >=50", accepted); end
    endtask

    initial begin
        rst = 1; rdy = 1; stall_i = 0; branch_enable_i = 0; branch_addr_i = '0; mem_grant_i = 1;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'ha0; mem[3] = 8'h00;
        test_reset();
        test_basic();
        test_stall();
        test_branch();
        test_grant();
        test_rdy();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
